alu_share_arb: RTL and testbench
================================

# alu_share_arb

Two-requester arbiter that time-shares one ALU instance between independent clients, e.g. the main datapath and an address or branch-compare helper. Each cycle it grants at most one valid request using round-robin priority and registers the operands. It evaluates the ALU on the registered operands and returns a registered result, tagged to the winning requester, two cycles after acceptance. The ALU itself stays purely combinational; this block supplies all sequencing and ownership.

## Interface
- No parameters. Data width is fixed at 32 and op width at 5.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  when high, no new request is granted. In-flight operations still complete.
- req0_valid  in  1  requester 0 has an operation.
- req0_a, req0_b  in  32  operands for requester 0.
- req0_op  in  5  ALU op code for requester 0.
- req0_ready  out  1  requester 0 is granted this cycle.
- req1_valid, req1_a, req1_b, req1_op, req1_ready: same as requester 0, for requester 1.
- rsp0_valid  out  1  one-cycle pulse: result on rsp_res/rsp_zero belongs to requester 0.
- rsp1_valid  out  1  one-cycle pulse: result belongs to requester 1.
- rsp_res  out  32  registered ALU result, shared by both response channels.
- rsp_zero  out  1  registered equality flag, 1 when a==b.
- busy  out  1  high while any stage holds a valid operation.

## Operation
- Handshake:
  - A transfer occurs in a cycle where reqN_valid and reqN_ready are both high.
  - reqN_ready is combinational: reqN_ready = grantN & ~stall.
  - Requesters must hold valid, a, b and op stable until the transfer; they may not withdraw.
- Arbitration:
  - If only one requester is valid, that one wins.
  - If both are valid, the winner is the requester not granted last.
  - The `last` pointer updates only on an actual transfer.
  - After reset, `last` = 1, so requester 0 wins the first tie.
- Stage 1 register: s1_valid, s1_id, s1_a, s1_b, s1_op. Loaded every cycle; s1_valid = transfer occurred.
- Stage 2 register: s2_valid, s2_id, s2_res, s2_zero. Captures the ALU output computed from the stage 1 register.
- Outputs:
  - rsp0_valid = s2_valid & ~s2_id.
  - rsp1_valid = s2_valid & s2_id.
  - rsp_res = s2_res; rsp_zero = s2_zero.
- There is no response backpressure. Clients must accept the response in the cycle it is presented.
- ALU op semantics (res):
  - 0: a+b
  - 1: a-b
  - 2: a|b
  - 3: {b[15:0],16'h0}
  - 4: a
  - 5: b << a[4:0]
  - any other code: 32'hffff_ffff
- Arithmetic is modulo 2^32; no overflow flag.
- zero is (a==b), independent of op.
- busy = s1_valid | s2_valid.

## Timing
- Reset values: s1_valid=0, s2_valid=0, rsp_res=0, rsp_zero=0, last=1, s1 data=0, s2 data=0.
- Consequently at reset: rsp0_valid=0, rsp1_valid=0, busy=0. req ready outputs follow their combinational equations.
- Latency: a transfer in cycle N produces its response pulse in cycle N+2.
- Throughput is one operation per cycle. Back-to-back transfers give back-to-back pulses.
- stall high in cycle N blocks transfers in N only. Stages 1 and 2 still advance, so prior operations respond on schedule.
- Reset mid-operation: all in-flight operations are dropped and no response pulse is produced.
- Continuous contention from both requesters yields a strict 0,1,0,1 alternation of grants.

## Structure
- Shared package `alu_pkg`:
  - op code constants: ALU_ADD=0, ALU_SUB=1, ALU_OR=2, ALU_LUI=3, ALU_PASSA=4, ALU_SLL=5.
  - the error result 32'hffff_ffff.
  - widths DATA_W=32 and OP_W=5.
- Sub-module: one combinational `alu_core` instance (a, b, aluop → res, zero), placed between stage 1 and stage 2.
- The arbiter logic and `last` pointer stay inline in this block.

## Test plan
- Single operation: req0 op=0, a=5, b=7 with req1 idle. Expect req0_ready=1 in the same cycle; two cycles later rsp0_valid=1, rsp_res=12, rsp_zero=0.
- Tie: both valid from reset. req0 op=1, a=3, b=3; req1 op=3, b=32'h0000_1234.
  - Grants alternate 0,1.
  - rsp0: res=0, zero=1.
  - Next cycle rsp1: res=32'h1234_0000.
- Shift and invalid op:
  - req1 op=5, a=4, b=1 → rsp_res=16.
  - req1 op=9 → rsp_res=32'hffff_ffff.
- Stall: assert stall for 3 cycles while both requesters are valid, one operation already in flight.
  - No ready during the stall.
  - The in-flight response still arrives on time.
  - Grants resume after stall drops, following the saved `last` pointer.
- Reset mid-flight: transfer an operation, drop rst_n in the next cycle. Expect no rsp pulse, busy=0, and the next tie going to requester 0.
- Back-to-back streaming: 8 consecutive req0 adds of i+i for i=0..7. Expect 8 consecutive rsp0 pulses with res=0,2,4,…,14.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, op codes, error result and pipeline stage records.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 5;

    localparam logic [OP_W-1:0] ALU_ADD   = 5'd0;
    localparam logic [OP_W-1:0] ALU_SUB   = 5'd1;
    localparam logic [OP_W-1:0] ALU_OR    = 5'd2;
    localparam logic [OP_W-1:0] ALU_LUI   = 5'd3;
    localparam logic [OP_W-1:0] ALU_PASSA = 5'd4;
    localparam logic [OP_W-1:0] ALU_SLL   = 5'd5;

    localparam logic [DATA_W-1:0] ALU_ERR_RES = 32'hffff_ffff;

    typedef struct packed {
        logic              valid;
        logic              id;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } s1_t;

    typedef struct packed {
        logic              valid;
        logic              id;
        logic [DATA_W-1:0] res;
        logic              zero;
    } s2_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU shared by both requesters; zero flags operand equality regardless of op.
module alu_core
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  aluop,
    output logic [31:0] res,
    output logic        zero
);

    always_comb begin
        res = ALU_ERR_RES;
        case (aluop)
            ALU_ADD:   res = a + b;
            ALU_SUB:   res = a - b;
            ALU_OR:    res = a | b;
            ALU_LUI:   res = {b[15:0], 16'h0000};
            ALU_PASSA: res = a;
            ALU_SLL:   res = b << a[4:0];
            default:   res = ALU_ERR_RES;
        endcase
        zero = (a == b);
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter time-sharing one ALU between two requesters; results return tagged two cycles after acceptance.
module alu_share_arb
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [4:0]  req0_op,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [4:0]  req1_op,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_res,
    output logic        rsp_zero,
    output logic        busy
);

    logic        last_q, last_d;
    s1_t         s1_q, s1_d;
    s2_t         s2_q, s2_d;
    logic        grant0, grant1;
    logic [31:0] alu_res;
    logic        alu_zero;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | last_q);
        grant1     = req1_valid & ~grant0;
        req0_ready = grant0 & ~stall;
        req1_ready = grant1 & ~stall;
    end

    always_comb begin
        last_d = last_q;
        if (req0_ready) begin
            last_d = 1'b0;
        end else if (req1_ready) begin
            last_d = 1'b1;
        end

        s1_d.valid = req0_ready | req1_ready;
        s1_d.id    = grant1;
        s1_d.a     = grant1 ? req1_a  : req0_a;
        s1_d.b     = grant1 ? req1_b  : req0_b;
        s1_d.op    = grant1 ? req1_op : req0_op;

        s2_d.valid = s1_q.valid;
        s2_d.id    = s1_q.id;
        s2_d.res   = alu_res;
        s2_d.zero  = alu_zero;
    end

    alu_core u_alu_core (
        .a     (s1_q.a),
        .b     (s1_q.b),
        .aluop (s1_q.op),
        .res   (alu_res),
        .zero  (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
            s1_q   <= '0;
            s2_q   <= '0;
        end else begin
            last_q <= last_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
        end
    end

    always_comb begin
        rsp0_valid = s2_q.valid & ~s2_q.id;
        rsp1_valid = s2_q.valid &  s2_q.id;
        rsp_res    = s2_q.res;
        rsp_zero   = s2_q.zero;
        busy       = s1_q.valid | s2_q.valid;
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed, table-driven bench for alu_share_arb plus hand-written multi-cycle sequences.
module tb_alu_share_arb;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        req0_valid;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [4:0]  req0_op;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [4:0]  req1_op;
    logic        req1_ready;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [31:0] rsp_res;
    logic        rsp_zero;
    logic        busy;

    int passCount  = 0;
    int checkCount = 0;

    typedef struct {
        logic        sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        logic [31:0] expRes;
        logic        expZero;
    } vec_t;

    vec_t vecs[10];

    alu_share_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_res    (rsp_res),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic [4:0] op0, input logic v1, input logic [31:0] a1,
                                 input logic [31:0] b1, input logic [4:0] op1);
        req0_valid = v0;
        req0_a     = a0;
        req0_b     = b0;
        req0_op    = op0;
        req1_valid = v1;
        req1_a     = a1;
        req1_b     = b1;
        req1_op    = op1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        stall = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        idleInputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic checkRsp(input string name, input logic exp0, input logic exp1,
                            input logic [31:0] expRes, input logic expZero);
        checkOutput({name, "_rsp0"}, {31'd0, rsp0_valid}, {31'd0, exp0});
        checkOutput({name, "_rsp1"}, {31'd0, rsp1_valid}, {31'd0, exp1});
        checkOutput({name, "_res"},  rsp_res, expRes);
        checkOutput({name, "_zero"}, {31'd0, rsp_zero}, {31'd0, expZero});
    endtask

    task automatic checkReady(input string name, input logic exp0, input logic exp1);
        checkOutput({name, "_rdy0"}, {31'd0, req0_ready}, {31'd0, exp0});
        checkOutput({name, "_rdy1"}, {31'd0, req1_ready}, {31'd0, exp1});
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'd5,          32'd7,          5'd0,  32'd12,          1'b0};
        vecs[1] = '{1'b1, 32'd4,          32'd1,          5'd5,  32'd16,          1'b0};
        vecs[2] = '{1'b1, 32'd2,          32'd2,          5'd9,  32'hffff_ffff,   1'b1};
        vecs[3] = '{1'b0, 32'h0000_00f0,  32'h0000_000f,  5'd2,  32'h0000_00ff,   1'b0};
        vecs[4] = '{1'b0, 32'hdead_beef,  32'd1,          5'd4,  32'hdead_beef,   1'b0};
        vecs[5] = '{1'b1, 32'd3,          32'd5,          5'd1,  32'hffff_fffe,   1'b0};
        vecs[6] = '{1'b0, 32'd0,          32'habcd_1234,  5'd3,  32'h1234_0000,   1'b0};
        vecs[7] = '{1'b1, 32'hffff_ffff,  32'd1,          5'd0,  32'd0,           1'b0};
        vecs[8] = '{1'b0, 32'd33,         32'd3,          5'd5,  32'd6,           1'b0};
        vecs[9] = '{1'b1, 32'd8,          32'd9,          5'd31, 32'hffff_ffff,   1'b0};

        rst_n = 1'b0;
        idleInputs();
        #2;
        checkRsp("reset", 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkReady("reset", 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-requester vectors: ready same cycle, response two cycles later.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (vecs[i].sel)
                applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
            else
                applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, 32'd0, 32'd0, 5'd0);
            #1;
            checkReady($sformatf("vec%0d", i), ~vecs[i].sel, vecs[i].sel);
            @(negedge clk);
            idleInputs();
            checkOutput($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd1);
            @(negedge clk);
            checkRsp($sformatf("vec%0d", i), ~vecs[i].sel, vecs[i].sel, vecs[i].expRes, vecs[i].expZero);
        end

        // Tie from reset: requester 0 first, then 1.
        doReset();
        applyStimulus(1'b1, 32'd3, 32'd3, 5'd1, 1'b1, 32'd0, 32'h0000_1234, 5'd3);
        #1;
        checkReady("tie_c0", 1'b1, 1'b0);
        @(negedge clk);
        checkReady("tie_c1", 1'b0, 1'b1);
        @(negedge clk);
        idleInputs();
        checkRsp("tie_r0", 1'b1, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        checkRsp("tie_r1", 1'b0, 1'b1, 32'h1234_0000, 1'b0);

        // Stall for three cycles with one operation in flight.
        doReset();
        applyStimulus(1'b1, 32'd1, 32'd1, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        stall = 1'b1;
        applyStimulus(1'b1, 32'd10, 32'd20, 5'd0, 1'b1, 32'd100, 32'd200, 5'd0);
        #1;
        checkReady("stall_c1", 1'b0, 1'b0);
        checkOutput("stall_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        checkReady("stall_c2", 1'b0, 1'b0);
        checkRsp("stall_inflight", 1'b1, 1'b0, 32'd2, 1'b1);
        @(negedge clk);
        checkReady("stall_c3", 1'b0, 1'b0);
        checkOutput("stall_c3_rsp0", {31'd0, rsp0_valid}, 32'd0);
        @(negedge clk);
        stall = 1'b0;
        #1;
        checkReady("stall_resume", 1'b0, 1'b1);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        checkReady("stall_next", 1'b1, 1'b0);
        @(negedge clk);
        idleInputs();
        checkRsp("stall_r1", 1'b0, 1'b1, 32'd300, 1'b0);
        @(negedge clk);
        checkRsp("stall_r0", 1'b1, 1'b0, 32'd30, 1'b0);

        // Reset while an operation is in flight drops it and restores the tie pointer.
        doReset();
        applyStimulus(1'b1, 32'd1, 32'd2, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        idleInputs();
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rstmid_rsp0", {31'd0, rsp0_valid}, 32'd0);
        @(negedge clk);
        checkOutput("rstmid_rsp0b", {31'd0, rsp0_valid | rsp1_valid}, 32'd0);
        checkOutput("rstmid_busy2", {31'd0, busy}, 32'd0);
        applyStimulus(1'b1, 32'd0, 32'd0, 5'd0, 1'b1, 32'd0, 32'd0, 5'd0);
        #1;
        checkReady("rstmid_tie", 1'b1, 1'b0);
        @(negedge clk);
        idleInputs();
        @(negedge clk);
        @(negedge clk);

        // Back-to-back stream of eight adds from requester 0.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k >= 2)
                checkRsp($sformatf("stream%0d", k - 2), 1'b1, 1'b0, 32'(2 * (k - 2)), 1'b1);
            if (k < 8) begin
                applyStimulus(1'b1, 32'(k), 32'(k), 5'd0, 1'b0, 32'd0, 32'd0, 5'd0);
                #1;
                checkOutput($sformatf("stream%0d_rdy0", k), {31'd0, req0_ready}, 32'd1);
            end else begin
                idleInputs();
            end
        end
        @(negedge clk);
        checkOutput("stream_end_busy", {31'd0, busy}, 32'd0);
        checkOutput("stream_end_rsp0", {31'd0, rsp0_valid}, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
